// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing a 16-bit asynchronous SRAM between an instruction-fetch
// read port and a data read/write port, each addressing 32-bit words as two halfwords.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W:0]   addr,
  inout  wire  [15:0]       data,
  output logic              wre,
  output logic              oute,
  output logic              chip_en,
  output logic              hb_mask,
  output logic              lb_mask,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    H_SETUP  = 3'd1,
    H_STROBE = 3'd2,
    L_SETUP  = 3'd3,
    L_STROBE = 3'd4,
    ACK      = 3'd5
  } state_t;

  typedef struct packed {
    logic              sel;    // 1 = data port owns the access
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } access_t;

  state_t          state, state_nxt;
  access_t         cur, incoming, acc_nxt;
  logic            last_d, grant_d, any_req, take;
  logic [15:0]     hi_buf, data_q;
  logic            data_oe;

  logic            active, high, strobe;
  logic            wre_nxt, oute_nxt, chip_en_nxt, hb_nxt, lb_nxt;
  logic            busy_nxt, i_ack_nxt, d_ack_nxt, data_oe_nxt;
  logic [ADDR_W:0] addr_nxt;
  logic [15:0]     data_nxt;

  assign any_req = i_req | d_req;
  assign grant_d = (i_req & d_req) ? ~last_d : d_req;
  assign take    = (state == IDLE) & any_req;

  // Request of the port that would be granted this cycle
  always_comb begin
    incoming     = '0;
    incoming.sel = grant_d;
    if (grant_d) begin
      incoming.we    = d_we;
      incoming.be    = d_be;
      incoming.addr  = d_addr;
      incoming.wdata = d_wdata;
    end else begin
      incoming.we    = 1'b0;
      incoming.be    = 4'hF;
      incoming.addr  = i_addr;
      incoming.wdata = 32'h0;
    end
  end

  // Next state, then the SRAM/ack values that state will present once registered
  always_comb begin
    state_nxt   = state;
    acc_nxt     = cur;
    active      = 1'b0;
    high        = 1'b0;
    strobe      = 1'b0;
    chip_en_nxt = 1'b1;
    oute_nxt    = 1'b1;
    wre_nxt     = 1'b1;
    hb_nxt      = 1'b1;
    lb_nxt      = 1'b1;
    addr_nxt    = addr;
    data_oe_nxt = 1'b0;
    data_nxt    = 16'h0;
    busy_nxt    = 1'b0;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;

    if (take) acc_nxt = incoming;

    case (state)
      IDLE: begin
        if (any_req) begin
          if (!incoming.we)                     state_nxt = H_SETUP;
          else if (incoming.be == 4'b0000)      state_nxt = ACK;
          else if (incoming.be[3:2] == 2'b00)   state_nxt = L_SETUP;
          else                                  state_nxt = H_SETUP;
        end
      end
      H_SETUP:  state_nxt = H_STROBE;
      H_STROBE: state_nxt = (cur.we && (cur.be[1:0] == 2'b00)) ? ACK : L_SETUP;
      L_SETUP:  state_nxt = L_STROBE;
      L_STROBE: state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    active = (state_nxt != IDLE) && (state_nxt != ACK);
    high   = (state_nxt == H_SETUP) || (state_nxt == H_STROBE);
    strobe = (state_nxt == H_STROBE) || (state_nxt == L_STROBE);

    chip_en_nxt = ~active;
    oute_nxt    = ~(active & ~acc_nxt.we);
    wre_nxt     = ~(active & acc_nxt.we & strobe);
    if (active) begin
      if (acc_nxt.we) begin
        hb_nxt = high ? ~acc_nxt.be[3] : ~acc_nxt.be[1];
        lb_nxt = high ? ~acc_nxt.be[2] : ~acc_nxt.be[0];
      end else begin
        hb_nxt = 1'b0;
        lb_nxt = 1'b0;
      end
      addr_nxt = {acc_nxt.addr, ~high};
    end
    data_oe_nxt = active & acc_nxt.we;
    data_nxt    = high ? acc_nxt.wdata[31:16] : acc_nxt.wdata[15:0];
    busy_nxt    = (state_nxt != IDLE);
    i_ack_nxt   = (state_nxt == ACK) & ~acc_nxt.sel;
    d_ack_nxt   = (state_nxt == ACK) &  acc_nxt.sel;
  end

  // State, latched request and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      cur     <= '0;
      hi_buf  <= 16'h0;
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
      wre     <= 1'b1;
      oute    <= 1'b1;
      chip_en <= 1'b1;
      hb_mask <= 1'b1;
      lb_mask <= 1'b1;
      addr    <= '0;
      data_oe <= 1'b0;
      data_q  <= 16'h0;
    end else begin
      state <= state_nxt;
      cur   <= acc_nxt;
      if (take) last_d <= grant_d;
      if ((state == H_STROBE) && !cur.we) hi_buf <= data;
      if ((state == L_STROBE) && !cur.we) begin
        if (cur.sel) d_rdata <= {hi_buf, data};
        else         i_rdata <= {hi_buf, data};
      end
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      busy    <= busy_nxt;
      wre     <= wre_nxt;
      oute    <= oute_nxt;
      chip_en <= chip_en_nxt;
      hb_mask <= hb_nxt;
      lb_mask <= lb_nxt;
      addr    <= addr_nxt;
      data_oe <= data_oe_nxt;
      data_q  <= data_nxt;
    end
  end

  assign data = data_oe ? data_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: halfword SRAM model, word-level reference memory and a
// transaction-level arbitration/latency model, directed scenarios then random traffic.
module tb_sram_arbiter;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned N_WORDS = 32;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [7:0]  word;
    logic [31:0] wdata;
  } txn_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [3:0]        d_be = 4'h0;
  logic [31:0]       d_wdata = 32'h0;
  logic              i_ack, d_ack;
  logic [31:0]       i_rdata, d_rdata;
  logic [ADDR_W:0]   addr;
  wire  [15:0]       data;
  logic              wre, oute, chip_en, hb_mask, lb_mask, busy;

  sram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .addr(addr), .data(data), .wre(wre), .oute(oute), .chip_en(chip_en),
    .hb_mask(hb_mask), .lb_mask(lb_mask), .busy(busy)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM: drives the bus on read; the probe drives 0 when the bus should be released
  logic [15:0] mem [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_val = '0;
  logic        probe_en = 1'b0;
  assign data = (!chip_en && !oute) ? mem[addr[8:0]] : (probe_en ? 16'h0000 : 16'hzzzz);

  int unsigned cyc = 0, both_ack = 0;
  int unsigned addr_q[$];
  int unsigned wre_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_addr] <= pre_val;
    if (!reset && !chip_en) addr_q.push_back(32'(addr));
    if (!chip_en && !wre) begin
      wre_q.push_back(cyc);
      if (!hb_mask) mem[addr[8:0]][15:8] <= data[15:8];
      if (!lb_mask) mem[addr[8:0]][7:0]  <= data[7:0];
    end
    if (i_ack && d_ack) both_ack <= both_ack + 1;
  end

  int unsigned checks = 0, errors = 0;
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_i_rdata = 32'h0, exp_d_rdata = 32'h0;
  bit          last_d = 1'b1;
  int unsigned k_i, k_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int unsigned lat_of(input txn_t t);
    int unsigned h = 0;
    if (!t.we) h = 2;
    else begin
      if (t.be[3:2] != 2'b00) h++;
      if (t.be[1:0] != 2'b00) h++;
    end
    return 2 * h + 1;
  endfunction

  task automatic model_access(input bit is_d, input txn_t t);
    if (!t.we) begin
      if (is_d) exp_d_rdata = ref_mem[t.word];
      else      exp_i_rdata = ref_mem[t.word];
    end else begin
      for (int b = 0; b < 4; b++)
        if (t.be[b]) ref_mem[t.word][8*b +: 8] = t.wdata[8*b +: 8];
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] v);
    pre_addr = a;
    pre_val  = v;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Issue one request per selected port from IDLE, wait for the acks, check latency and data
  task automatic run_txn(input bit use_i, input txn_t ti, input bit use_d, input txn_t td,
                         input string tag);
    int unsigned k = 0, exp_i, exp_d, n_i = 0, n_d = 0;
    int unsigned li, ld;
    bit first_d;
    txn_t tr;
    tr = ti;
    tr.we = 1'b0;
    li = lat_of(tr);
    ld = lat_of(td);
    first_d = (use_i && use_d) ? !last_d : use_d;
    if (use_i && use_d) begin
      exp_i  = first_d ? ld + 1 + li : li;
      exp_d  = first_d ? ld : li + 1 + ld;
      last_d = !first_d;
    end else begin
      exp_i  = li;
      exp_d  = ld;
      last_d = use_d;
    end
    k_i = 0;
    k_d = 0;
    i_req   = use_i;
    i_addr  = ADDR_W'(ti.word);
    d_req   = use_d;
    d_we    = td.we;
    d_be    = td.be;
    d_addr  = ADDR_W'(td.word);
    d_wdata = td.wdata;
    while (k < 40 && ((use_i && n_i == 0) || (use_d && n_d == 0))) begin
      tick();
      k++;
      if (i_ack) begin
        n_i++; k_i = k; i_req = 1'b0;
        model_access(1'b0, tr);
        chk({tag, " i_rdata"}, i_rdata, exp_i_rdata);
        chk({tag, " d_rdata_hold"}, d_rdata, exp_d_rdata);
      end
      if (d_ack) begin
        n_d++; k_d = k; d_req = 1'b0;
        model_access(1'b1, td);
        chk({tag, " d_rdata"}, d_rdata, exp_d_rdata);
        chk({tag, " i_rdata_hold"}, i_rdata, exp_i_rdata);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    chk({tag, " idle_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " i_ack_count"}, n_i, use_i ? 32'd1 : 32'd0);
    chk({tag, " d_ack_count"}, n_d, use_d ? 32'd1 : 32'd0);
    chk({tag, " i_latency"}, k_i, use_i ? exp_i : 32'd0);
    chk({tag, " d_latency"}, k_d, use_d ? exp_d : 32'd0);
  endtask

  function automatic int unsigned q_at(input int unsigned idx, input bit use_wre);
    if (use_wre) return (idx < wre_q.size()) ? wre_q[idx] : 32'hFFFF_FFFF;
    return (idx < addr_q.size()) ? addr_q[idx] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    txn_t ti, td;
    logic [31:0] v;
    int unsigned sa, sw, mode;

    // Reset, with SRAM and reference memory loaded while it is held
    for (int w = 0; w < N_WORDS; w++) begin
      v = (w == 5) ? 32'h1234_5678 : $urandom();
      ref_mem[w] = v;
      preload(9'(2 * w), v[31:16]);
      preload(9'(2 * w + 1), v[15:0]);
    end
    chk("rst i_ack", {31'd0, i_ack}, 32'd0);
    chk("rst d_ack", {31'd0, d_ack}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ctrl", {27'd0, wre, oute, chip_en, hb_mask, lb_mask}, 32'h1F);
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    probe_en = 1'b1;
    #1;
    chk("rst data_z", {16'd0, data}, 32'd0);
    probe_en = 1'b0;
    reset = 1'b0;
    tick();

    // Instruction read of word 5
    td = '0;
    ti = '{we: 1'b0, be: 4'hF, word: 8'd5, wdata: 32'h0};
    sa = addr_q.size();
    sw = wre_q.size();
    run_txn(1'b1, ti, 1'b0, td, "rd5");
    chk("rd5 value", i_rdata, 32'h1234_5678);
    chk("rd5 addr_cnt", addr_q.size() - sa, 32'd4);
    chk("rd5 addr0", q_at(sa, 1'b0), 32'hA);
    chk("rd5 addr1", q_at(sa + 1, 1'b0), 32'hA);
    chk("rd5 addr2", q_at(sa + 2, 1'b0), 32'hB);
    chk("rd5 addr3", q_at(sa + 3, 1'b0), 32'hB);
    chk("rd5 no_wre", wre_q.size() - sw, 32'd0);
    chk("rd5 addr_hold", 32'(addr), 32'hB);

    // Full write of word 3
    td = '{we: 1'b1, be: 4'hF, word: 8'd3, wdata: 32'hDEAD_BEEF};
    sw = wre_q.size();
    run_txn(1'b0, ti, 1'b1, td, "wr3");
    chk("wr3 k", k_d, 32'd5);
    chk("wr3 wre_cnt", wre_q.size() - sw, 32'd2);
    chk("wr3 wre_gap", q_at(sw + 1, 1'b1) - q_at(sw, 1'b1), 32'd2);
    chk("wr3 mem6", {16'd0, mem[6]}, 32'hDEAD);
    chk("wr3 mem7", {16'd0, mem[7]}, 32'hBEEF);

    // Low-half-only write of word 3
    td = '{we: 1'b1, be: 4'b0011, word: 8'd3, wdata: 32'h0000_CAFE};
    sa = addr_q.size();
    run_txn(1'b0, ti, 1'b1, td, "wrlo");
    chk("wrlo k", k_d, 32'd3);
    chk("wrlo addr_cnt", addr_q.size() - sa, 32'd2);
    chk("wrlo addr0", q_at(sa, 1'b0), 32'h7);
    chk("wrlo addr1", q_at(sa + 1, 1'b0), 32'h7);
    chk("wrlo mem6", {16'd0, mem[6]}, 32'hDEAD);
    chk("wrlo mem7", {16'd0, mem[7]}, 32'hCAFE);

    // Reset during L_STROBE of a write to a scratch word
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    d_addr = ADDR_W'(32'h80); d_wdata = 32'h1357_9BDF;
    for (int c = 0; c < 4; c++) tick();
    chk("abort in_lstrobe", {30'd0, chip_en, wre}, 32'd0);
    chk("abort addr", 32'(addr), 32'h101);
    reset = 1'b1;
    d_req = 1'b0;
    probe_en = 1'b1;
    tick();
    chk("abort ctrl", {30'd0, wre, chip_en}, 32'h3);
    chk("abort data_z", {16'd0, data}, 32'd0);
    chk("abort d_ack", {31'd0, d_ack}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort i_rdata", i_rdata, 32'd0);
    probe_en = 1'b0;
    reset = 1'b0;
    last_d = 1'b1;
    exp_i_rdata = 32'h0;
    exp_d_rdata = 32'h0;
    tick();
    chk("abort after d_ack", {31'd0, d_ack}, 32'd0);
    chk("abort after busy", {31'd0, busy}, 32'd0);

    // Both ports requesting: instruction first after reset, then strict alternation
    for (int r = 0; r < 2; r++) begin
      ti = '{we: 1'b0, be: 4'hF, word: 8'(r + 10), wdata: 32'h0};
      td = '{we: 1'b0, be: 4'hF, word: 8'(r + 20), wdata: 32'h0};
      run_txn(1'b1, ti, 1'b1, td, "tie");
      chk("tie i_first", k_i, 32'd5);
      chk("tie d_second", k_d, 32'd11);
    end

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 2);
      ti = '{we: 1'b0, be: 4'hF, word: 8'($urandom_range(0, N_WORDS - 1)), wdata: 32'h0};
      td.word  = 8'($urandom_range(0, N_WORDS - 1));
      td.we    = 1'($urandom_range(0, 1));
      td.be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      td.wdata = $urandom();
      run_txn(mode != 1, ti, mode != 0, td, "rnd");
    end

    chk("never_both_acks", both_ack, 32'd0);
    for (int w = 0; w < N_WORDS; w++)
      chk("final mem", {mem[9'(2 * w)], mem[9'(2 * w + 1)]}, ref_mem[w]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 17, 32-bit word address width of both requester ports; SRAM address width SHALL be ADDR_W+1.
REQ-002 Ports (name direction width meaning):
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-fetch read request.
- i_addr  in  ADDR_W  instruction word address.
- i_ack  out  1  one-cycle completion pulse, instruction port.
- i_rdata  out  32  fetched word.
- d_req  in  1  data-port request.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  write byte enables; bit3 = bits 31:24.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse, data port.
- d_rdata  out  32  read word.
- addr  out  ADDR_W+1  SRAM halfword address.
- data  inout  16  SRAM data bus.
- wre, oute, chip_en, hb_mask, lb_mask  out  1 each  SRAM write enable, output enable, chip enable, high-byte mask, low-byte mask; all active-low.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 Each 32-bit word SHALL map to two halfwords: addr = {word,0} holds bits 31:16 (high half); addr = {word,1} holds bits 15:0 (low half).
REQ-004 FSM states SHALL be IDLE, H_SETUP, H_STROBE, L_SETUP, L_STROBE, ACK, each lasting exactly one cycle.
REQ-005 In IDLE, at an edge with any req high, the FSM SHALL latch the granted port's select, address, we, be and wdata, then go to H_SETUP.
REQ-006 Transition order SHALL be H_SETUP->H_STROBE->L_SETUP->L_STROBE->ACK->IDLE.
REQ-007 The latency from a req sampled in IDLE to its ack SHALL be 5 cycles for a full access.
REQ-008 Arbitration SHALL be round-robin:
- Single request: grant that port.
- Both requesting: grant the port not granted last.
- The last-grant register SHALL update only on grant.
REQ-009 Requesters SHALL hold req and inputs stable until ack; a req still high in IDLE after ack SHALL be treated as a new request.
REQ-010 In ACK, the arbiter SHALL pulse ack for the granted port only.
REQ-011 On a read ack, the arbiter SHALL update that port's rdata; rdata SHALL hold its value until that port's next read ack.
REQ-012 Reads SHALL access both halves with hb_mask = lb_mask = 0, oute = 0 in SETUP and STROBE states, and wre = 1.
REQ-013 Read data SHALL be captured from data at the edge ending H_STROBE (bits 31:16) and L_STROBE (bits 15:0).
REQ-014 Writes SHALL drive data in SETUP and STROBE with oute = 1, wre = 0 in STROBE only.
- High half: hb_mask = ~be[3], lb_mask = ~be[2].
- Low half: hb_mask = ~be[1], lb_mask = ~be[0].
REQ-015 Write half-skipping:
- If be[3:2] = 00, IDLE SHALL go to L_SETUP.
- If be[1:0] = 00, H_STROBE SHALL go to ACK.
- If be = 0000, IDLE SHALL go directly to ACK with no SRAM activity.
REQ-016 chip_en SHALL be 0 in SETUP and STROBE states and 1 in IDLE and ACK.
REQ-017 data SHALL be high-Z whenever no write is in a SETUP or STROBE state.
REQ-018 addr SHALL hold its last value in IDLE and ACK.
REQ-019 All SRAM control outputs and ack outputs SHALL be registered (glitch-free).

Reset
REQ-020 While reset is high at an edge:
- state SHALL be IDLE and last-grant = data port, so the first tie goes to the instruction port.
- i_ack, d_ack and busy SHALL be 0.
- wre, oute, chip_en, hb_mask and lb_mask SHALL be 1.
- data SHALL be high-Z, addr = 0, i_rdata = d_rdata = 0.
REQ-021 Reset asserted mid-access SHALL abort the access at that edge with no ack; a partial write may leave one half written.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset held 2 cycles -> all outputs per REQ-020, data = Z.
- SRAM[0x0A] = 0x1234, [0x0B] = 0x5678; i_req with i_addr = 0x00005 -> addr 0x0000A then 0x0000B; i_ack 5 cycles after the req is sampled; i_rdata = 0x12345678.
- d_we = 1, d_be = 1111, d_addr = 3, d_wdata = 0xDEADBEEF -> SRAM[6] = 0xDEAD, [7] = 0xBEEF; wre low for exactly 2 non-adjacent cycles; d_ack at 5 cycles.
- d_be = 0011 write of 0x0000CAFE to word 3 -> only addr 7 accessed; SRAM[6] unchanged; d_ack 3 cycles after sample.
- i_req and d_req both held high after reset -> grants alternate instr, data, instr, data; one ack per 6 cycles; never both acks at once.
- Reset asserted in L_STROBE of a write -> next cycle wre = chip_en = 1, data = Z, no d_ack; FSM in IDLE.
